aes_iter_core: RTL and testbench
================================

# aes_iter_core

Iterative AES encryption core with a valid/ready handshake: one round per clock, on-the-fly key expansion, and key length selectable at elaboration (AES-128 or AES-256). It is the area-optimised, parametrised successor to the fully unrolled AES-128 pipeline. It sits between a block-source FIFO and a ciphertext sink, trading throughput for roughly one tenth of the round logic.

## Interface
- `KEY_BITS`, default 128: key length. Legal values are 128 and 256; any other value is an elaboration error.
- `NR`, default derived as `KEY_BITS/32 + 6`: round count. It is a localparam, not a user-settable parameter.
- `clk` input, 1 bit: single clock; all flops are on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `in_state`/`in_key` hold a block to encrypt.
- `in_ready` output, 1 bit: the core can accept a block.
- `in_state` input, 128 bits: plaintext block, FIPS-197 byte order (byte 0 = bits [127:120]).
- `in_key` input, `KEY_BITS` bits: cipher key, same byte order.
- `out_valid` output, 1 bit: `out_data` holds a finished ciphertext.
- `out_ready` input, 1 bit: the sink accepts `out_data`.
- `out_data` output, 128 bits: ciphertext.
- `blk_count` output, 32 bits: only present with `AES_PERF_CNT_EN`.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `in_ready` is 1.
  - On `in_valid & in_ready`, the core loads `st <= in_state ^ in_key[KEY_BITS-1 -: 128]` (round 0), loads the key register with `in_key`, sets `rcon` = 8'h01 and `round` = 1, then goes to RUN.
- RUN:
  - Each cycle applies one round with the current round key and computes the next round key.
  - Rounds 1..NR-1 apply SubBytes, ShiftRows, MixColumns and AddRoundKey.
  - Round NR omits MixColumns. After it, the state moves to DONE and `out_valid` goes to 1.
- DONE:
  - `out_data` and `out_valid` are held stable while `out_ready` is 0.
  - On `out_ready`, the state returns to IDLE and `out_valid` goes to 0.
- Key schedule follows FIPS-197, with round keys generated on the fly:
  - 128-bit keys: one 4-word schedule step per round, using RotWord, SubWord and Rcon.
  - 256-bit keys: the key register holds 8 words. Each step alternates between the RotWord/SubWord/Rcon form and the SubWord-only form, and `rcon` advances every second step.
- `rcon` is updated by xtime (multiply by 2 in GF(2^8), reduction polynomial 0x11B).
- `in_state` and `in_key` are sampled only at the accept edge. Later changes to them have no effect on the block in flight.
- `in_ready` is 0 in RUN and DONE; `in_valid` in those states is ignored and no data is dropped.
- `round` is 4 bits wide and counts 1..NR without wrapping.
- Reset while in RUN or DONE aborts the block; the FSM returns to IDLE.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_data` = 128'h0.
  - FSM = IDLE; `round` = 0; `rcon` = 8'h01.
  - `blk_count` = 0.
- Latency: `out_valid` rises exactly NR clock edges after the accept edge (10 for AES-128, 14 for AES-256).
- Throughput with `out_ready` tied high: one block every NR+2 cycles (accept, NR rounds, DONE→IDLE).
- `out_data` is registered; there is no combinational path from any input to any output.

## Configuration
- `AES_PERF_CNT_EN` defined:
  - `blk_count` port exists.
  - It increments by 1 on each `out_valid & out_ready` handshake and wraps from 32'hFFFF_FFFF to 0.
  - It is cleared only by `rst_n`.
- `AES_PERF_CNT_EN` undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `aes_pkg` holds:
  - the 256-entry S-box constant and a `sbox` function;
  - the `xtime` and `mix_column` functions;
  - the FSM state enum;
  - `function nr_of(int key_bits)`.
- Sub-module `aes_round` is purely combinational. It takes the state, round key and a `last` flag, and returns the next state.
- Key expansion and the FSM live in `aes_iter_core`.

## Test plan
- AES-128, vector 1: key 2b7e1516_28aed2a6_abf71588_09cf4f3c, state 3243f6a8_885a308d_313198a2_e0370734 → `out_data` 3925841d_02dc09fb_dc118597_196a0b32, with `out_valid` high 10 edges after accept.
- AES-128, vector 2: key 00010203_…_0c0d0e0f, state 00112233_…_ccddeeff → 69c4e0d8_6a7b0430_d8cdb780_70b4c55a.
- AES-128, zero inputs: key 0, state 0 → 66e94bd4_ef8a2c3b_884cfa59_ca342b2e.
- AES-256 (`KEY_BITS`=256): key 00010203_…_1c1d1e1f, state 00112233_…_ccddeeff → 8ea2b7ca_516745bf_eafc4990_4b496089, with latency 14.
- Backpressure:
  - Hold `out_ready` = 0 for 5 cycles after `out_valid`; `out_data` and `out_valid` must stay stable and `in_ready` must stay 0.
  - Toggle `in_state` during RUN; the result must be unchanged.
- Reset and counter:
  - Assert `rst_n` = 0 at round 5; all outputs must return to reset values immediately.
  - After release, a new block completes correctly.
  - With `AES_PERF_CNT_EN`, three handshakes give `blk_count` = 3.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) helpers, MixColumns and FSM state type.
package aes_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} aes_state_e;

    // Entry 0 sits in the top byte so that row order matches the usual printed table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Multiply by 2 in GF(2^8), polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; last_i skips MixColumns.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] sr;
    logic [127:0] mc;

    // SubBytes + ShiftRows (byte 4*col+row), then MixColumns and AddRoundKey.
    always_comb begin
        sr = '0;
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sbox(state_i[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
        state_o = (last_i ? sr : mc) ^ rkey_i;
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core, one round per clock, on-the-fly key expansion.
// Optional block counter enabled by defining AES_PERF_CNT_EN.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_state,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data
`ifdef AES_PERF_CNT_EN
    ,
    output logic [31:0]         blk_count
`endif
);

    localparam int unsigned NR = nr_of(int'(KEY_BITS));
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    aes_state_e          state_q, state_d;
    logic [127:0]        st_q, st_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [7:0]          rcon_q, rcon_d;
    logic [3:0]          round_q, round_d;

    logic [KEY_BITS-1:0] key_next;
    logic [127:0]        rkey;
    logic [7:0]          rcon_next;
    logic [127:0]        rnd_out;
    logic                last;

    assign last = (round_q == LAST_ROUND);

    if (KEY_BITS == 256) begin : g_ks256
        logic [31:0] t, n0, n1, n2, n3;
        // key_q holds 8 words; its low half is the current round key, the new 4 words
        // alternate between the Rcon form (odd rounds) and the SubWord-only form.
        always_comb begin
            if (round_q[0]) begin
                t = sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h0};
            end else begin
                t = sub_word(key_q[31:0]);
            end
            n0 = key_q[255:224] ^ t;
            n1 = key_q[223:192] ^ n0;
            n2 = key_q[191:160] ^ n1;
            n3 = key_q[159:128] ^ n2;
            key_next  = {key_q[127:0], n0, n1, n2, n3};
            rkey      = key_q[127:0];
            rcon_next = round_q[0] ? xtime(rcon_q) : rcon_q;
        end
    end else begin : g_ks128
        logic [31:0] t, n0, n1, n2, n3;
        // key_q holds the previous round key; this round's key is derived from it.
        always_comb begin
            t  = sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h0};
            n0 = key_q[127:96] ^ t;
            n1 = key_q[95:64] ^ n0;
            n2 = key_q[63:32] ^ n1;
            n3 = key_q[31:0] ^ n2;
            key_next  = {n0, n1, n2, n3};
            rkey      = key_next;
            rcon_next = xtime(rcon_q);
        end
    end

    aes_round u_round (
        .state_i (st_q),
        .rkey_i  (rkey),
        .last_i  (last),
        .state_o (rnd_out)
    );

    // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        key_d   = key_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    st_d    = in_state ^ in_key[KEY_BITS-1 -: 128];
                    key_d   = in_key;
                    rcon_d  = 8'h01;
                    round_d = 4'd1;
                    state_d = StRun;
                end
            end
            StRun: begin
                st_d   = rnd_out;
                key_d  = key_next;
                rcon_d = rcon_next;
                if (last) begin
                    state_d = StDone;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            st_q    <= '0;
            key_q   <= '0;
            rcon_q  <= 8'h01;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = st_q;

`ifdef AES_PERF_CNT_EN
    logic [31:0] cnt_q;

    // Count output handshakes; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else if (out_valid && out_ready) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign blk_count = cnt_q;
`endif

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed-vector bench for aes_iter_core (AES-128 and AES-256 instances).
module tb_aes_iter_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         v1, r1, ov1, or1;
    logic [127:0] s1, k1, od1;
    logic         v2, r2, ov2, or2;
    logic [127:0] s2, od2;
    logic [255:0] k2;
`ifdef AES_PERF_CNT_EN
    logic [31:0]  bc1, bc2;
`endif

    int total = 0;
    int bad = 0;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [255:0] KEY_C =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_iter_core #(.KEY_BITS(128)) u_dut128 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .in_ready  (r1),
        .in_state  (s1),
        .in_key    (k1),
        .out_valid (ov1),
        .out_ready (or1),
        .out_data  (od1)
`ifdef AES_PERF_CNT_EN
        ,
        .blk_count (bc1)
`endif
    );

    aes_iter_core #(.KEY_BITS(256)) u_dut256 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v2),
        .in_ready  (r2),
        .in_state  (s2),
        .in_key    (k2),
        .out_valid (ov2),
        .out_ready (or2),
        .out_data  (od2)
`ifdef AES_PERF_CNT_EN
        ,
        .blk_count (bc2)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Encrypt one block on the 128-bit core; scrambles inputs during RUN and optionally
    // holds out_ready low for `hold` cycles while offering another block.
    task automatic run128(input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] exp, input string tag, input int hold);
        int lat;
        @(negedge clk);
        check({tag, " in_ready idle"}, 128'(r1), 128'd1);
        s1 = pt;
        k1 = key;
        v1 = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        v1 = 1'b0;
        while (!ov1 && lat < 40) begin
            @(negedge clk);
            lat++;
            s1 = {$urandom, $urandom, $urandom, $urandom};
            k1 = ~k1;
            v1 = lat[0];
        end
        check({tag, " latency"}, 128'(lat), 128'd10);
        check({tag, " data"}, od1, exp);
        for (int i = 0; i < hold; i++) begin
            v1 = 1'b1;
            @(negedge clk);
            check({tag, " hold data"}, od1, exp);
            check({tag, " hold valid"}, 128'(ov1), 128'd1);
            check({tag, " hold in_ready"}, 128'(r1), 128'd0);
        end
        v1 = 1'b0;
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        check({tag, " valid drop"}, 128'(ov1), 128'd0);
        check({tag, " in_ready back"}, 128'(r1), 128'd1);
    endtask

    task automatic run256();
        int lat;
        @(negedge clk);
        check("aes256 in_ready idle", 128'(r2), 128'd1);
        s2 = PT_B;
        k2 = KEY_C;
        v2 = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        v2 = 1'b0;
        while (!ov2 && lat < 40) begin
            @(negedge clk);
            lat++;
            s2 = ~s2;
            k2 = ~k2;
        end
        check("aes256 latency", 128'(lat), 128'd14);
        check("aes256 data", od2, CT_C);
        or2 = 1'b1;
        @(negedge clk);
        or2 = 1'b0;
        check("aes256 valid drop", 128'(ov2), 128'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        v1 = 1'b0; or1 = 1'b0; s1 = '0; k1 = '0;
        v2 = 1'b0; or2 = 1'b0; s2 = '0; k2 = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 128'(r1), 128'd1);
        check("reset out_valid", 128'(ov1), 128'd0);
        check("reset out_data", od1, 128'h0);
`ifdef AES_PERF_CNT_EN
        check("reset blk_count", 128'(bc1), 128'd0);
`endif
        rst_n = 1'b1;

        run128(KEY_A, PT_A, CT_A, "vec1", 0);
        run128(KEY_B, PT_B, CT_B, "vec2", 5);
        run128(128'h0, 128'h0, CT_Z, "zero", 0);
        run256();
`ifdef AES_PERF_CNT_EN
        check("blk_count 128 before reset", 128'(bc1), 128'd3);
        check("blk_count 256", 128'(bc2), 128'd1);
`endif

        // Abort a block at round 5.
        @(negedge clk);
        s1 = PT_A;
        k1 = KEY_A;
        v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 128'(ov1), 128'd0);
        check("abort in_ready", 128'(r1), 128'd1);
        check("abort out_data", od1, 128'h0);
`ifdef AES_PERF_CNT_EN
        check("abort blk_count", 128'(bc1), 128'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run128(KEY_A, PT_A, CT_A, "post-reset vec1", 0);
        run128(KEY_B, PT_B, CT_B, "post-reset vec2", 0);
        run128(128'h0, 128'h0, CT_Z, "post-reset zero", 0);
`ifdef AES_PERF_CNT_EN
        check("blk_count three", 128'(bc1), 128'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
